// File: rtl/babbage_pkg.sv
// Shared types and default constants for the babbage engine arbiter and its helpers.
package babbage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_N   = 4;
    localparam int DEF_R   = 4;
    localparam int DEF_TMO = 64;

    // Watchdog counter width for the default timeout.
    localparam int WDOG_W  = $clog2(DEF_TMO);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of i_pend at or after i_ptr, wrapping.
module rr_pick #(
    parameter int R = 4
) (
    input  logic [R-1:0]         i_pend,
    input  logic [$clog2(R)-1:0] i_ptr,
    output logic [$clog2(R)-1:0] o_gnt,
    output logic                 o_found
);

    localparam int IW = $clog2(R);

    logic [IW:0] w_sum;

    always_comb begin
        o_gnt   = '0;
        o_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < R; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(R)) begin
                w_sum = w_sum - (IW+1)'(R);
            end
            if (!o_found && i_pend[w_sum[IW-1:0]]) begin
                o_found = 1'b1;
                o_gnt   = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/babbage_arbiter.sv
// Round-robin scheduler sharing one babbage_engine between R requesters, with a watchdog.
// Optional one-entry result cache enabled by defining BABBAGE_ARB_CACHE_EN.
module babbage_arbiter
    import babbage_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int R   = DEF_R,
    parameter int TMO = DEF_TMO
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [R-1:0]         req,
    input  logic [R*N-1:0]       req_i,
    output logic [R-1:0]         pend,
    output logic                 resp_valid,
    output logic [$clog2(R)-1:0] resp_id,
    output logic [2**N-1:0]      resp_fn,
    output logic                 resp_err,
    output logic                 eng_start,
    output logic [N-1:0]         eng_i,
    input  logic                 eng_ready,
    input  logic                 eng_done_tick,
    input  logic [2**N-1:0]      eng_fn
);

    localparam int FW = 2**N;
    localparam int IW = $clog2(R);
    localparam int WW = $clog2(TMO);

    state_t          r_state;
    state_t          w_next;
    logic [R-1:0]    r_pend;
    logic [N-1:0]    r_idx [R];
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gnt;
    logic [WW-1:0]   r_wdog;
    logic            r_resp_valid;
    logic [IW-1:0]   r_resp_id;
    logic [FW-1:0]   r_resp_fn;
    logic            r_resp_err;
    logic            r_eng_start;
    logic [N-1:0]    r_eng_i;

    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic [R-1:0]    w_free;
    logic [R-1:0]    w_take;
    logic            w_wdog_exp;
    logic            w_hit;
    logic [FW-1:0]   w_hit_fn;

    rr_pick #(.R(R)) u_pick (
        .i_pend  (r_pend),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick),
        .o_found (w_found)
    );

    // The slot being answered is reusable in the same cycle, so a client can chain jobs.
    assign w_free     = (r_state == RESP) ? (R'(1) << r_gnt) : '0;
    assign w_take     = req & (~r_pend | w_free);
    assign w_wdog_exp = (r_wdog == WW'(TMO - 2));

`ifdef BABBAGE_ARB_CACHE_EN
    logic            r_cache_vld;
    logic [N-1:0]    r_cache_i;
    logic [FW-1:0]   r_cache_fn;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cache_vld <= 1'b0;
            r_cache_i   <= '0;
            r_cache_fn  <= '0;
        end else if (r_state == WAIT && eng_done_tick) begin
            r_cache_vld <= 1'b1;
            r_cache_i   <= r_eng_i;
            r_cache_fn  <= eng_fn;
        end
    end

    assign w_hit    = (r_state == IDLE) && w_found && r_cache_vld && (r_idx[w_pick] == r_cache_i);
    assign w_hit_fn = r_cache_fn;
`else
    assign w_hit    = 1'b0;
    assign w_hit_fn = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_next = RESP;
                end else if (w_found && eng_ready) begin
                    w_next = ISSUE;
                end
            end
            ISSUE:   w_next = WAIT;
            WAIT: begin
                if (eng_done_tick || w_wdog_exp) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend       <= '0;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_wdog       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_fn    <= '0;
            r_resp_err   <= 1'b0;
            r_eng_start  <= 1'b0;
            r_eng_i      <= '0;
            for (int r = 0; r < R; r++) begin
                r_idx[r] <= '0;
            end
        end else begin
            r_resp_valid <= 1'b0;
            r_eng_start  <= 1'b0;
            r_pend       <= (r_pend & ~w_free) | w_take;
            for (int r = 0; r < R; r++) begin
                if (w_take[r]) begin
                    r_idx[r] <= req_i[r*N +: N];
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt <= w_pick;
                    end
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= w_pick;
                        r_resp_fn    <= w_hit_fn;
                        r_resp_err   <= 1'b0;
                    end else if (w_found && eng_ready) begin
                        r_eng_start <= 1'b1;
                        r_eng_i     <= r_idx[w_pick];
                    end
                end
                ISSUE: r_wdog <= '0;
                WAIT: begin
                    // A real completion wins over a watchdog expiry in the same cycle.
                    if (eng_done_tick) begin
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_gnt;
                        r_resp_fn    <= eng_fn;
                        r_resp_err   <= 1'b0;
                    end else if (w_wdog_exp) begin
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_gnt;
                        r_resp_fn    <= '0;
                        r_resp_err   <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                RESP: r_ptr <= (r_gnt == IW'(R - 1)) ? '0 : r_gnt + IW'(1);
                default: ;
            endcase
        end
    end

    assign pend       = r_pend;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_fn    = r_resp_fn;
    assign resp_err   = r_resp_err;
    assign eng_start  = r_eng_start;
    assign eng_i      = r_eng_i;

endmodule
